// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: issues one word request at a time, steers the PC on
// redirects, discards wrong-path responses and hands fetched words to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        drop_q, drop_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    logic [31:0] redirect_tgt;
    logic        req_fire;

    assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid = (state_q == S_REQ) && !instr_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;

        if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    // A request already marked for dropping must not overwrite the
                    // redirect target held in pc with its own sequential successor.
                    if (redirect_valid) begin
                        pc_d   = redirect_tgt;
                        drop_d = 1'b1;
                    end else if (!drop_q) begin
                        pc_d = req_addr_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_req_valid) begin
                        drop_d = 1'b1;
                    end else begin
                        req_addr_d = redirect_tgt;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_d       = redirect_tgt;
                        req_addr_d = redirect_tgt;
                    end else begin
                        req_addr_d = pc_q;
                        if (!drop_q) begin
                            instr_valid_d = 1'b1;
                            instr_data_d  = imem_rsp_data;
                            instr_pc_d    = req_addr_q;
                        end
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Handshake stability guarantees offered to memory and decode.
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        imem_req_valid && !imem_req_ready |=> imem_req_valid && $stable(imem_req_addr));

    a_instr_hold: assert property (@(posedge clk) disable iff (rst)
        instr_valid && !instr_ready && !redirect_valid
        |=> instr_valid && $stable(instr_data) && $stable(instr_pc));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, redirect/reset corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, imem_req_ready, imem_rsp_valid, instr_ready;
    logic [31:0] redirect_pc, imem_rsp_data;

    logic        a_req_valid, w_req_valid, a_instr_valid, w_instr_valid;
    logic [31:0] a_req_addr, w_req_addr, a_instr_data, w_instr_data, a_instr_pc, w_instr_pc;

    logic        sel;
    logic        s_req_valid, s_instr_valid;
    logic [31:0] s_req_addr, s_instr_data, s_instr_pc;

    assign s_req_valid   = sel ? w_req_valid   : a_req_valid;
    assign s_req_addr    = sel ? w_req_addr    : a_req_addr;
    assign s_instr_valid = sel ? w_instr_valid : a_instr_valid;
    assign s_instr_data  = sel ? w_instr_data  : a_instr_data;
    assign s_instr_pc    = sel ? w_instr_pc    : a_instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(a_instr_valid), .instr_ready(instr_ready),
        .instr_data(a_instr_data), .instr_pc(a_instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc)
    );

    int checks = 0;
    int errors = 0;

    // memory and handshake environment
    bit          mem_busy;
    int          mem_cnt;
    int          mem_delay;
    logic [31:0] mem_addr;
    bit          g_rr, g_ir;

    // reference model: program-order view of fetch
    bit          model_on;
    bit          m_inflight, m_wrong, m_buf_v;
    logic [31:0] m_pc, m_req_addr, m_buf_d, m_buf_pc, m_stream;

    typedef struct {
        bit          rr;
        bit          ir;
        bit          e_rv;
        logic [31:0] e_ra;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vt[15];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_init(input logic [31:0] base);
        m_pc = base; m_req_addr = base; m_stream = base;
        m_inflight = 0; m_wrong = 0; m_buf_v = 0;
        m_buf_d = '0; m_buf_pc = '0;
    endtask

    task automatic model_check();
        bit want;
        want = !m_inflight && !m_buf_v;
        chk1("m_req_valid", s_req_valid, want);
        if (want) chk32("m_req_addr", s_req_addr, m_req_addr);
        chk1("m_instr_valid", s_instr_valid, m_buf_v);
        if (m_buf_v) begin
            chk32("m_instr_pc", s_instr_pc, m_buf_pc);
            chk32("m_instr_data", s_instr_data, m_buf_d);
        end
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          want;
        tgt  = {redirect_pc[31:2], 2'b00};
        want = !m_inflight && !m_buf_v;
        // every word decode takes must be the next correct-path instruction
        if (s_instr_valid && instr_ready && !redirect_valid) begin
            chk32("stream_pc", s_instr_pc, m_stream);
            chk32("stream_data", s_instr_data, mem_word(m_stream));
            m_stream = m_stream + 32'd4;
        end
        if (m_buf_v && instr_ready) m_buf_v = 0;
        if (!m_inflight) begin
            if (want && imem_req_ready) begin
                m_inflight = 1;
                m_pc       = redirect_valid ? tgt : (m_wrong ? m_pc : m_req_addr + 32'd4);
                m_wrong    = m_wrong || redirect_valid;
            end else if (redirect_valid) begin
                m_pc = tgt;
                if (want) m_wrong = 1;
                else m_req_addr = tgt;
            end
        end else if (imem_rsp_valid) begin
            if (!m_wrong && !redirect_valid) begin
                m_buf_v = 1; m_buf_d = imem_rsp_data; m_buf_pc = m_req_addr;
            end
            m_inflight = 0;
            m_wrong    = 0;
            if (redirect_valid) m_pc = tgt;
            m_req_addr = m_pc;
        end else if (redirect_valid) begin
            m_wrong = 1;
            m_pc    = tgt;
        end
        if (redirect_valid) begin
            m_buf_v  = 0;
            m_stream = tgt;
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance to the next falling edge.
    task automatic tick(input bit r, input bit rv, input logic [31:0] rpc);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = r ? 1'b0 : g_rr;
        instr_ready    = g_ir;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_busy       = 0;
            end
        end
        if (s_req_valid && imem_req_ready) begin
            mem_busy = 1; mem_cnt = mem_delay; mem_addr = s_req_addr;
        end
        if (model_on && !r) model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic s);
        sel = s; mem_busy = 0; model_on = 0; g_rr = 1; g_ir = 1; mem_delay = 1;
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        chk1("rst_req_valid", s_req_valid, 1'b1);
        chk1("rst_instr_valid", s_instr_valid, 1'b0);
        chk32("rst_instr_data", s_instr_data, 32'h0);
        chk32("rst_instr_pc", s_instr_pc, 32'h0);
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!s_req_valid && n < 20) begin
            tick(1'b0, 1'b0, '0);
            n++;
        end
        chk1("req_seen", s_req_valid, 1'b1);
        chk32("req_addr", s_req_addr, exp_addr);
    endtask

    task automatic wait_instr(input logic [31:0] exp_pc);
        int n = 0;
        while (!s_instr_valid && n < 20) begin
            tick(1'b0, 1'b0, '0);
            n++;
        end
        chk1("instr_seen", s_instr_valid, 1'b1);
        chk32("instr_pc", s_instr_pc, exp_pc);
        chk32("instr_data", s_instr_data, mem_word(exp_pc));
    endtask

    task automatic stream(input logic [31:0] base, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            wait_req(a);
            tick(1'b0, 1'b0, '0);
            wait_instr(a);
            tick(1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[11] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h108};
        vt[14] = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0};

        sel = 1'b0; rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
        @(negedge clk);

        // streaming and backpressure, cycle by cycle
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            chk1("tbl_req_valid", s_req_valid, vt[i].e_rv);
            if (vt[i].e_rv) chk32("tbl_req_addr", s_req_addr, vt[i].e_ra);
            chk1("tbl_instr_valid", s_instr_valid, vt[i].e_iv);
            if (vt[i].e_iv) begin
                chk32("tbl_instr_pc", s_instr_pc, vt[i].e_pc);
                chk32("tbl_instr_data", s_instr_data, mem_word(vt[i].e_pc));
            end
            g_rr = vt[i].rr;
            g_ir = vt[i].ir;
            tick(1'b0, 1'b0, '0);
        end

        // redirect while waiting; the late 0x108 response must not reach the buffer
        do_reset(1'b0);
        stream(32'h100, 2);
        wait_req(32'h108);
        mem_delay = 3;
        tick(1'b0, 1'b0, '0);
        g_ir = 0;
        tick(1'b0, 1'b1, 32'h200);
        mem_delay = 1;
        wait_req(32'h200);
        chk1("wait_redir_no_wrong", s_instr_valid, 1'b0);
        g_ir = 1;
        tick(1'b0, 1'b0, '0);
        wait_instr(32'h200);

        // redirect while request is presented but not accepted
        do_reset(1'b0);
        stream(32'h100, 3);
        g_rr = 0;
        wait_req(32'h10C);
        tick(1'b0, 1'b1, 32'h303);
        for (int i = 0; i < 3; i++) begin
            chk1("pend_req_valid", s_req_valid, 1'b1);
            chk32("pend_req_addr", s_req_addr, 32'h10C);
            tick(1'b0, 1'b0, '0);
        end
        g_rr = 1; g_ir = 0;
        tick(1'b0, 1'b0, '0);
        wait_req(32'h300);
        chk1("pend_no_wrong", s_instr_valid, 1'b0);
        g_ir = 1;
        tick(1'b0, 1'b0, '0);
        wait_instr(32'h300);

        // redirect in the same cycle as the response
        do_reset(1'b0);
        stream(32'h100, 1);
        wait_req(32'h104);
        tick(1'b0, 1'b0, '0);
        g_ir = 0;
        tick(1'b0, 1'b1, 32'h400);
        chk1("rsp_redir_iv", s_instr_valid, 1'b0);
        chk1("rsp_redir_req_valid", s_req_valid, 1'b1);
        chk32("rsp_redir_req_addr", s_req_addr, 32'h400);
        g_ir = 1;
        tick(1'b0, 1'b0, '0);
        wait_instr(32'h400);

        // redirect flushes a full, stalled buffer
        do_reset(1'b0);
        stream(32'h100, 1);
        wait_req(32'h104);
        tick(1'b0, 1'b0, '0);
        g_ir = 0;
        tick(1'b0, 1'b0, '0);
        chk1("full_iv", s_instr_valid, 1'b1);
        chk32("full_pc", s_instr_pc, 32'h104);
        tick(1'b0, 1'b1, 32'h500);
        chk1("flush_iv0", s_instr_valid, 1'b0);
        chk1("flush_req_valid", s_req_valid, 1'b1);
        chk32("flush_req_addr", s_req_addr, 32'h500);
        tick(1'b0, 1'b0, '0);
        chk1("flush_iv1", s_instr_valid, 1'b0);
        g_ir = 1;
        wait_instr(32'h500);

        // address wrap, then reset while a response is outstanding
        do_reset(1'b1);
        stream(32'hFFFF_FFFC, 1);
        wait_req(32'h0000_0000);
        mem_delay = 3;
        tick(1'b0, 1'b0, '0);
        g_rr = 0;
        tick(1'b1, 1'b0, '0);
        chk1("rst_wait_req_valid", s_req_valid, 1'b1);
        chk32("rst_wait_req_addr", s_req_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        chk1("stale_rsp_iv", s_instr_valid, 1'b0);
        chk1("stale_rsp_req_valid", s_req_valid, 1'b1);
        chk32("stale_rsp_req_addr", s_req_addr, 32'hFFFF_FFFC);
        g_rr = 1; mem_delay = 1;
        tick(1'b0, 1'b0, '0);
        wait_instr(32'hFFFF_FFFC);

        // randomized traffic against the reference model
        do_reset(1'b0);
        model_init(32'h100);
        model_on = 1;
        for (int i = 0; i < 3000; i++) begin
            model_check();
            g_rr      = ($urandom_range(3) != 0);
            g_ir      = ($urandom_range(3) != 0);
            mem_delay = int'($urandom_range(3, 1));
            if ($urandom_range(9) == 0) tick(1'b0, 1'b1, $urandom());
            else tick(1'b0, 1'b0, $urandom());
        end
        model_check();
        model_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
